mult_div_unit: RTL and testbench

//   Iterative multiply/divide unit (MIPS MULT/MULTU/DIV/DIVU, MTHI/MTLO) with HI/LO result registers.

---
 rtl/mdu_pkg.sv | 23 ++
 rtl/mdu_if.sv | 32 +++
 rtl/mdu_sign_fix.sv | 58 +++++
 rtl/mult_div_unit.sv | 157 +++++++++++++++
 tb/tb_mult_div_unit.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the iterative multiply/divide unit.
//   - MDU_WIDTH : default operand/result width
//   - mdu_op_e  : operation encodings driven on the op port
//   - mdu_state_e : control FSM states
// Optional feature macro used by the unit: MDU_SIGNED_EN (signed MULT/DIV).
package mdu_pkg;

    localparam int MDU_WIDTH = 32;

    typedef enum logic [1:0] {
        MDU_MULTU = 2'b00,
        MDU_MULT  = 2'b01,
        MDU_DIVU  = 2'b10,
        MDU_DIV   = 2'b11
    } mdu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } mdu_state_e;

endpackage

// File: rtl/mdu_if.sv
// mdu_if: request/result bundle between the pipeline and the multiply/divide unit.
//   start/op/rs_val/rt_val : operation request (rs_val/rt_val from regfile reads)
//   wr_hi/wr_lo/wr_data    : MTHI/MTLO writes
//   busy/done/div_zero     : status back to the control unit
//   hi/lo                  : result registers for MFHI/MFLO
// The master drives requests; the slave (mult_div_unit) drives status and results.
interface mdu_if #(
    parameter int WIDTH = mdu_pkg::MDU_WIDTH
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] rs_val;
    logic [WIDTH-1:0] rt_val;
    logic             wr_hi;
    logic             wr_lo;
    logic [WIDTH-1:0] wr_data;
    logic             busy;
    logic             done;
    logic             div_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, rs_val, rt_val, wr_hi, wr_lo, wr_data,
        input  busy, done, div_zero, hi, lo
    );

    modport slave (
        input  start, op, rs_val, rt_val, wr_hi, wr_lo, wr_data,
        output busy, done, div_zero, hi, lo
    );
endinterface

// File: rtl/mdu_sign_fix.sv
// mdu_sign_fix: combinational sign handling for signed MULT/DIV.
// Only instantiated when MDU_SIGNED_EN is defined.
//   signed_op, rs_val, rt_val -> rs_abs, rt_abs, rs_neg, rt_neg  (load-time magnitudes)
//   fix_div, fix_rs_neg, fix_rt_neg, res_hi, res_lo -> fix_hi, fix_lo  (FIX-stage correction)
// Mul: the 2*WIDTH product is negated when operand signs differ.
// Div: quotient negated when signs differ; remainder follows the dividend's sign.
module mdu_sign_fix #(
    parameter int WIDTH = mdu_pkg::MDU_WIDTH
) (
    input  logic             signed_op,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    output logic [WIDTH-1:0] rs_abs,
    output logic [WIDTH-1:0] rt_abs,
    output logic             rs_neg,
    output logic             rt_neg,
    input  logic             fix_div,
    input  logic             fix_rs_neg,
    input  logic             fix_rt_neg,
    input  logic [WIDTH-1:0] res_hi,
    input  logic [WIDTH-1:0] res_lo,
    output logic [WIDTH-1:0] fix_hi,
    output logic [WIDTH-1:0] fix_lo
);

    // Two's complement negate; -(-2^(W-1)) wraps to itself, which is the
    // correct unsigned magnitude 2^(W-1).
    function automatic logic [WIDTH-1:0] cond_neg(input logic neg, input logic [WIDTH-1:0] v);
        logic signed [WIDTH-1:0] sv;
        sv = signed'(v);
        return neg ? unsigned'(-sv) : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] cond_neg2(input logic neg, input logic [2*WIDTH-1:0] v);
        logic signed [2*WIDTH-1:0] sv;
        sv = signed'(v);
        return neg ? unsigned'(-sv) : v;
    endfunction

    logic [2*WIDTH-1:0] prod_fix;

    assign rs_neg = signed_op & rs_val[WIDTH-1];
    assign rt_neg = signed_op & rt_val[WIDTH-1];
    assign rs_abs = cond_neg(rs_neg, rs_val);
    assign rt_abs = cond_neg(rt_neg, rt_val);

    assign prod_fix = cond_neg2(fix_rs_neg ^ fix_rt_neg, {res_hi, res_lo});

    always_comb begin
        fix_hi = prod_fix[2*WIDTH-1:WIDTH];
        fix_lo = prod_fix[WIDTH-1:0];
        if (fix_div) begin
            fix_hi = cond_neg(fix_rs_neg, res_hi);
            fix_lo = cond_neg(fix_rs_neg ^ fix_rt_neg, res_lo);
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative MIPS multiply/divide unit with HI/LO registers.
//   clk, rst : clock and synchronous active-high reset
//   bus      : mdu_if.slave (start/op/rs_val/rt_val request, wr_hi/wr_lo/wr_data
//              MTHI/MTLO, busy/done/div_zero status, hi/lo results)
// Operation: IDLE -> RUN (WIDTH shift-add or restoring shift-subtract steps)
// -> FIX (sign correction, result write) -> IDLE. Result and done appear
// WIDTH+1 edges after the start edge for every op.
// Config macro: MDU_SIGNED_EN enables signed MULT/DIV via mdu_sign_fix; when
// undefined op[0] is ignored and no sign logic is built.
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH
) (
    input  logic clk,
    input  logic rst,
    mdu_if.slave bus
);

    localparam int CW = $clog2(WIDTH);

    mdu_state_e       state_q, state_d;
    logic [CW-1:0]    cnt_q;
    logic             done_q;
    logic             div_zero_q;
    logic [WIDTH-1:0] hi_q, lo_q;

    // Working registers: p_hi/p_lo hold the partial product (mul) or
    // remainder/quotient-dividend shift pair (div); mcand holds the
    // multiplicand or divisor magnitude.
    logic [WIDTH-1:0] p_hi_q, p_lo_q, mcand_q;
    logic             is_div_q;
    logic             dz_q;

    logic [WIDTH-1:0] rs_abs, rt_abs, fix_hi, fix_lo;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_trial;
    logic             div_ok;
    logic             load;

`ifdef MDU_SIGNED_EN
    logic rs_neg, rt_neg;
    logic rs_neg_q, rt_neg_q;

    mdu_sign_fix #(.WIDTH(WIDTH)) u_sign_fix (
        .signed_op  (bus.op[0]),
        .rs_val     (bus.rs_val),
        .rt_val     (bus.rt_val),
        .rs_abs     (rs_abs),
        .rt_abs     (rt_abs),
        .rs_neg     (rs_neg),
        .rt_neg     (rt_neg),
        .fix_div    (is_div_q),
        .fix_rs_neg (rs_neg_q),
        .fix_rt_neg (rt_neg_q),
        .res_hi     (p_hi_q),
        .res_lo     (p_lo_q),
        .fix_hi     (fix_hi),
        .fix_lo     (fix_lo)
    );

    always_ff @(posedge clk) begin
        if (load) begin
            rs_neg_q <= rs_neg;
            rt_neg_q <= rt_neg;
        end
    end
`else
    logic op_sign_unused;

    assign op_sign_unused = bus.op[0];
    assign rs_abs         = bus.rs_val;
    assign rt_abs         = bus.rt_val;
    assign fix_hi         = p_hi_q;
    assign fix_lo         = p_lo_q;
`endif

    assign load = (state_q == IDLE) && bus.start;

    // Mul step adds the multiplicand when the current multiplier bit is set;
    // the carry lands in bit WIDTH and is shifted back into p_hi.
    assign mul_sum = {1'b0, p_hi_q} + (p_lo_q[0] ? {1'b0, mcand_q} : '0);

    // Restoring div step: the partial remainder is always below the divisor,
    // so a set top bit of the trial difference means "borrow, keep old value".
    assign div_trial = {p_hi_q, p_lo_q[WIDTH-1]} - {1'b0, mcand_q};
    assign div_ok    = ~div_trial[WIDTH];

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = RUN;
            RUN:     if (cnt_q == '0) state_d = FIX;
            FIX:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Control state and architectural result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
        end else begin
            state_q <= state_d;
            done_q  <= (state_q == FIX);
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        cnt_q <= CW'(WIDTH - 1);
                    end else begin
                        if (bus.wr_hi) hi_q <= bus.wr_data;
                        if (bus.wr_lo) lo_q <= bus.wr_data;
                    end
                end
                RUN: cnt_q <= cnt_q - 1'b1;
                FIX: begin
                    hi_q       <= fix_hi;
                    // Divide by zero reports an all-ones quotient regardless
                    // of any sign correction.
                    lo_q       <= (is_div_q && dz_q) ? '1 : fix_lo;
                    div_zero_q <= is_div_q && dz_q;
                end
                default: ;
            endcase
        end
    end

    // Datapath: loaded at the start edge, stepped once per RUN cycle.
    always_ff @(posedge clk) begin
        if (load) begin
            mcand_q  <= rt_abs;
            p_hi_q   <= '0;
            p_lo_q   <= rs_abs;
            is_div_q <= bus.op[1];
            dz_q     <= (bus.rt_val == '0);
        end else if (state_q == RUN) begin
            if (is_div_q) begin
                p_hi_q <= div_ok ? div_trial[WIDTH-1:0] : {p_hi_q[WIDTH-2:0], p_lo_q[WIDTH-1]};
                p_lo_q <= {p_lo_q[WIDTH-2:0], div_ok};
            end else begin
                {p_hi_q, p_lo_q} <= {mul_sum, p_lo_q[WIDTH-1:1]};
            end
        end
    end

    assign bus.busy     = (state_q != IDLE);
    assign bus.done     = done_q;
    assign bus.div_zero = div_zero_q;
    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed bench for mult_div_unit (WIDTH=32).
// Expected values depend on MDU_SIGNED_EN where signed ops are exercised.
module tb_mult_div_unit;
    import mdu_pkg::*;

    localparam int W = 32;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mdu_if #(.WIDTH(W)) bus ();

    mult_div_unit #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Present a request for one cycle; operands are scrambled right after
    // the start edge, so the result must come from the latched copies.
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int e0);
        @(negedge clk);
        bus.start  = 1'b1;
        bus.op     = op;
        bus.rs_val = a;
        bus.rt_val = b;
        @(posedge clk);
        #1;
        e0         = cyc;
        bus.start  = 1'b0;
        bus.rs_val = $urandom;
        bus.rt_val = $urandom;
        chk("accept_busy", {63'd0, bus.busy}, 64'd1);
        chk("accept_done_low", {63'd0, bus.done}, 64'd0);
    endtask

    task automatic wait_done(input int e0, output int lat, output bit busy_ok);
        busy_ok = 1'b1;
        lat     = -1;
        for (int i = 0; i < 100; i++) begin
            if (bus.done) begin
                lat = cyc - e0;
                break;
            end
            if (!bus.busy) busy_ok = 1'b0;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_hi,
                          input logic [31:0] exp_lo, input logic exp_dz);
        int e0, lat;
        bit bok;
        issue(op, a, b, e0);
        wait_done(e0, lat, bok);
        chk({tag, "_latency"}, 64'(lat), 64'd33);
        chk({tag, "_busy_run"}, {63'd0, bok}, 64'd1);
        chk({tag, "_busy_done"}, {63'd0, bus.busy}, 64'd0);
        chk({tag, "_hi"}, {32'd0, bus.hi}, {32'd0, exp_hi});
        chk({tag, "_lo"}, {32'd0, bus.lo}, {32'd0, exp_lo});
        chk({tag, "_dz"}, {63'd0, bus.div_zero}, {63'd0, exp_dz});
    endtask

    initial begin
        int  e0, lat;
        bit  bok, seen;

        rst         = 1'b1;
        bus.start   = 1'b0;
        bus.op      = MDU_MULTU;
        bus.rs_val  = '0;
        bus.rt_val  = '0;
        bus.wr_hi   = 1'b0;
        bus.wr_lo   = 1'b0;
        bus.wr_data = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", {63'd0, bus.busy}, 64'd0);
        chk("rst_done", {63'd0, bus.done}, 64'd0);
        chk("rst_dz", {63'd0, bus.div_zero}, 64'd0);
        chk("rst_hi", {32'd0, bus.hi}, 64'd0);
        chk("rst_lo", {32'd0, bus.lo}, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op("multu_max", MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
`ifdef MDU_SIGNED_EN
        run_op("mult_m3x5", MDU_MULT, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
        run_op("mult_m3xm5", MDU_MULT, 32'hFFFF_FFFD, 32'hFFFF_FFFB, 32'd0, 32'd15, 1'b0);
`else
        run_op("mult_m3x5", MDU_MULT, 32'hFFFF_FFFD, 32'd5, 32'h0000_0004, 32'hFFFF_FFF1, 1'b0);
        run_op("mult_m3xm5", MDU_MULT, 32'hFFFF_FFFD, 32'hFFFF_FFFB, 32'hFFFF_FFF8, 32'd15, 1'b0);
`endif
        run_op("divu_15_4", MDU_DIVU, 32'd15, 32'd4, 32'd3, 32'd3, 1'b0);
`ifdef MDU_SIGNED_EN
        run_op("div_m7_2", MDU_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        run_op("div_7_m2", MDU_DIV, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 1'b0);
        run_op("div_min_m1", MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0);
`else
        run_op("div_m7_2", MDU_DIV, 32'hFFFF_FFF9, 32'd2, 32'd1, 32'h7FFF_FFFC, 1'b0);
        run_op("div_7_m2", MDU_DIV, 32'd7, 32'hFFFF_FFFE, 32'd7, 32'd0, 1'b0);
        run_op("div_min_m1", MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0);
`endif
        run_op("divu_10_0", MDU_DIVU, 32'd10, 32'd0, 32'h0000_000A, 32'hFFFF_FFFF, 1'b1);
        run_op("multu_2_3", MDU_MULTU, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0);
        run_op("div_m5_0", MDU_DIV, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1);
        run_op("multu_2_3b", MDU_MULTU, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0);

        // Re-pulsed start and an MTHI attempt while busy are both ignored.
        issue(MDU_MULTU, 32'd7, 32'd9, e0);
        repeat (5) @(posedge clk);
        @(negedge clk);
        bus.start   = 1'b1;
        bus.op      = MDU_DIVU;
        bus.rs_val  = 32'd100;
        bus.rt_val  = 32'd3;
        bus.wr_hi   = 1'b1;
        bus.wr_data = 32'h0000_0BAD;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.wr_hi = 1'b0;
        chk("busy_wrhi_ignored", {32'd0, bus.hi}, 64'd0);
        wait_done(e0, lat, bok);
        chk("restart_latency", 64'(lat), 64'd33);
        chk("restart_busy", {63'd0, bok}, 64'd1);
        chk("restart_hi", {32'd0, bus.hi}, 64'd0);
        chk("restart_lo", {32'd0, bus.lo}, 64'd63);

        // Reset in the middle of RUN aborts with no result and no done.
        issue(MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, e0);
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_busy", {63'd0, bus.busy}, 64'd0);
        chk("abort_hi", {32'd0, bus.hi}, 64'd0);
        chk("abort_lo", {32'd0, bus.lo}, 64'd0);
        chk("abort_done", {63'd0, bus.done}, 64'd0);
        @(negedge clk);
        rst  = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (bus.done) seen = 1'b1;
        end
        chk("abort_no_done", {63'd0, seen}, 64'd0);

        // MTHI alone, then MTHI+MTLO together.
        @(negedge clk);
        bus.wr_hi   = 1'b1;
        bus.wr_data = 32'h0000_1234;
        @(posedge clk);
        #1;
        bus.wr_hi = 1'b0;
        chk("mthi_hi", {32'd0, bus.hi}, 64'h1234);
        chk("mthi_lo", {32'd0, bus.lo}, 64'd0);
        chk("mthi_done", {63'd0, bus.done}, 64'd0);
        @(negedge clk);
        bus.wr_hi   = 1'b1;
        bus.wr_lo   = 1'b1;
        bus.wr_data = 32'h0000_55AA;
        @(posedge clk);
        #1;
        bus.wr_hi = 1'b0;
        bus.wr_lo = 1'b0;
        chk("mthilo_hi", {32'd0, bus.hi}, 64'h55AA);
        chk("mthilo_lo", {32'd0, bus.lo}, 64'h55AA);
        chk("mthilo_done", {63'd0, bus.done}, 64'd0);

        // MTLO in the same cycle as start is dropped; the op runs normally.
        @(negedge clk);
        bus.wr_lo   = 1'b1;
        bus.wr_data = 32'h0000_DEAD;
        bus.start   = 1'b1;
        bus.op      = MDU_MULTU;
        bus.rs_val  = 32'd2;
        bus.rt_val  = 32'd3;
        @(posedge clk);
        #1;
        e0        = cyc;
        bus.start = 1'b0;
        bus.wr_lo = 1'b0;
        chk("startwin_lo", {32'd0, bus.lo}, 64'h55AA);
        chk("startwin_busy", {63'd0, bus.busy}, 64'd1);
        wait_done(e0, lat, bok);
        chk("startwin_latency", 64'(lat), 64'd33);
        chk("startwin_hi", {32'd0, bus.hi}, 64'd0);
        chk("startwin_res_lo", {32'd0, bus.lo}, 64'd6);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
